// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between EX and the data-memory stage.
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag doubleword-crossing accesses instead of splitting them.
module lsu_align #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] rd_waddr_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  output logic              ren_o,
  output logic              wen_o,
  output logic [XLEN-1:0]   raddr_o,
  output logic [XLEN-1:0]   waddr_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [7:0]        wmask_o,
  input  logic [XLEN-1:0]   rdata_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   rd_wdata_o,
  output logic [REG_AW-1:0] rd_waddr_o,
  output logic              reg_wen_o,
  output logic [XLEN-1:0]   inst_addr_o,
  output logic              misalign_o
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_CAP,
    S_RESP
  } state_t;

  state_t state;

  logic                accept;
  logic [2:0]          f_off;
  logic [3:0]          f_end;
  logic                f_cross;
  logic                f_issue;
  logic [7:0]          f_bmask;
  logic [XLEN-1:0]     f_dmask;
  logic [2*XLEN-1:0]   f_sdata;
  logic [15:0]         f_smask;

  logic                ld_q;
  logic [1:0]          size_q;
  logic                zext_q;
  logic [2:0]          off_q;
  logic                cross_q;
  logic [XLEN-1:0]     a0_q;
  logic [2*XLEN-1:0]   sdata_q;
  logic [15:0]         smask_q;
  logic [REG_AW-1:0]   rd_q;
  logic [XLEN-1:0]     pc_q;
  logic [XLEN-1:0]     lo_q;

  logic [2*XLEN-1:0]   ld_win;
  logic [XLEN-1:0]     ld_res;

  // Shift the beat window down to the addressed byte, then trim to size and extend.
  function automatic logic [63:0] load_ext(input logic [127:0] w, input logic [2:0] off,
                                           input logic [1:0] size, input logic zext);
    logic [127:0] s;
    logic [63:0]  r;
    s = w >> {off, 3'b000};
    case (size)
      2'd0: r = zext ? {56'b0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
      2'd1: r = zext ? {48'b0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2: r = zext ? {32'b0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      2'd3: r = s[63:0];
    endcase
    return r;
  endfunction

  // Request decode: byte lane mask, crossing detect and the 128-bit lane-shifted store image.
  always_comb begin
    accept = req_valid_i & req_ready_o & (is_load_i | is_store_i);
    f_off  = addr_i[2:0];
    case (funct3_i[1:0])
      2'd0: begin f_bmask = 8'h01; f_dmask = 64'h0000_0000_0000_00FF; end
      2'd1: begin f_bmask = 8'h03; f_dmask = 64'h0000_0000_0000_FFFF; end
      2'd2: begin f_bmask = 8'h0F; f_dmask = 64'h0000_0000_FFFF_FFFF; end
      2'd3: begin f_bmask = 8'hFF; f_dmask = 64'hFFFF_FFFF_FFFF_FFFF; end
    endcase
    f_end   = {1'b0, f_off} + (4'd1 << funct3_i[1:0]);
    f_cross = f_end > 4'd8;
    f_issue = !(TRAP_EN && f_cross);
    f_sdata = {{XLEN{1'b0}}, wdata_i & f_dmask} << {f_off, 3'b000};
    f_smask = {8'b0, f_bmask} << f_off;
  end

  always_comb begin
    ld_win = cross_q ? {rdata_i, lo_q} : {{XLEN{1'b0}}, rdata_i};
    ld_res = load_ext(ld_win, off_q, size_q, zext_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      req_ready_o  <= 1'b1;
      ren_o        <= 1'b0;
      wen_o        <= 1'b0;
      raddr_o      <= '0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      wmask_o      <= '0;
      resp_valid_o <= 1'b0;
      rd_wdata_o   <= '0;
      rd_waddr_o   <= '0;
      reg_wen_o    <= 1'b0;
      inst_addr_o  <= '0;
      misalign_o   <= 1'b0;
      ld_q         <= 1'b0;
      size_q       <= '0;
      zext_q       <= 1'b0;
      off_q        <= '0;
      cross_q      <= 1'b0;
      a0_q         <= '0;
      sdata_q      <= '0;
      smask_q      <= '0;
      rd_q         <= '0;
      pc_q         <= '0;
      lo_q         <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      reg_wen_o    <= 1'b0;
      misalign_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state       <= S_ACC0;
            req_ready_o <= 1'b0;
            ld_q        <= is_load_i;
            size_q      <= funct3_i[1:0];
            zext_q      <= funct3_i[2];
            off_q       <= f_off;
            cross_q     <= f_cross;
            a0_q        <= {addr_i[XLEN-1:3], 3'b000};
            sdata_q     <= f_sdata;
            smask_q     <= f_smask;
            rd_q        <= rd_waddr_i;
            pc_q        <= inst_addr_i;
            lo_q        <= '0;
            ren_o       <= f_issue & is_load_i;
            wen_o       <= f_issue & !is_load_i;
            raddr_o     <= {addr_i[XLEN-1:3], 3'b000};
            waddr_o     <= {addr_i[XLEN-1:3], 3'b000};
            wdata_o     <= (f_issue && !is_load_i) ? f_sdata[XLEN-1:0] : '0;
            wmask_o     <= (f_issue && !is_load_i) ? f_smask[7:0] : '0;
          end
        end
        S_ACC0: begin
          if (cross_q && !TRAP_EN) begin
            state   <= S_ACC1;
            ren_o   <= ld_q;
            wen_o   <= !ld_q;
            raddr_o <= a0_q + XLEN'(8);
            waddr_o <= a0_q + XLEN'(8);
            wdata_o <= ld_q ? '0 : sdata_q[2*XLEN-1:XLEN];
            wmask_o <= ld_q ? '0 : smask_q[15:8];
          end else begin
            ren_o   <= 1'b0;
            wen_o   <= 1'b0;
            wdata_o <= '0;
            wmask_o <= '0;
            if (ld_q && !cross_q) begin
              state <= S_CAP;
            end else begin
              // Stores and trapped crossing accesses complete here with no write-back.
              state        <= S_RESP;
              resp_valid_o <= 1'b1;
              misalign_o   <= cross_q;
              rd_wdata_o   <= '0;
              rd_waddr_o   <= rd_q;
              inst_addr_o  <= pc_q;
            end
          end
        end
        S_ACC1: begin
          ren_o   <= 1'b0;
          wen_o   <= 1'b0;
          wdata_o <= '0;
          wmask_o <= '0;
          if (ld_q) begin
            lo_q  <= rdata_i;
            state <= S_CAP;
          end else begin
            state        <= S_RESP;
            resp_valid_o <= 1'b1;
            rd_wdata_o   <= '0;
            rd_waddr_o   <= rd_q;
            inst_addr_o  <= pc_q;
          end
        end
        S_CAP: begin
          state        <= S_RESP;
          resp_valid_o <= 1'b1;
          rd_wdata_o   <= ld_res;
          rd_waddr_o   <= rd_q;
          reg_wen_o    <= (rd_q != '0);
          inst_addr_o  <= pc_q;
        end
        S_RESP: begin
          state       <= S_IDLE;
          req_ready_o <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
